// File: rtl/pcie_bram_s6_core.sv
// Simple-dual-port block RAM slice for the PCIe TX/RX buffer banks.
// One 18 Kb Spartan-6 BRAM per instance, read-first, optional output reg.
module pcie_bram_s6_core #(
   parameter int DOB_REG = 0,
   parameter int WIDTH   = 36
) (
   input  logic             user_clk_i,
   input  logic             reset_i,
   input  logic             wen_i,
   input  logic [11:0]      waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             ren_i,
   input  logic             rce_i,
   input  logic [11:0]      raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int AW = (WIDTH == 36) ? 9  :
                       (WIDTH == 18) ? 10 :
                       (WIDTH == 9)  ? 11 : 12;
   localparam int DEPTH = 1 << AW;

   if (WIDTH != 36 && WIDTH != 18 && WIDTH != 9 && WIDTH != 4) begin : g_bad_width
      $fatal(1, "pcie_bram_s6_core: illegal WIDTH %0d", WIDTH);
   end

   logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
   logic [WIDTH-1:0] latch_q;
   logic [AW-1:0]    wa;
   logic [AW-1:0]    ra;

   // Upper address bits are dropped so addresses alias modulo the depth.
   assign wa = waddr_i[AW-1:0];
   assign ra = raddr_i[AW-1:0];

   wire unused_ok = ^{waddr_i, raddr_i, rce_i};

   always_ff @(posedge user_clk_i) begin
      if (wen_i)
         mem[wa] <= wdata_i;
   end

   // Non-blocking read of mem gives read-first on a same-address collision.
   always_ff @(posedge user_clk_i) begin
      if (reset_i)
         latch_q <= '0;
      else if (ren_i)
         latch_q <= mem[ra];
   end

   if (DOB_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] oreg_q;

      always_ff @(posedge user_clk_i) begin
         if (reset_i)
            oreg_q <= '0;
         else if (rce_i)
            oreg_q <= latch_q;
      end

      assign rdata_o = oreg_q;
   end else begin : g_noreg
      assign rdata_o = latch_q;
   end

endmodule

// File: tb/tb_pcie_bram_s6_core.sv
// Directed bench for pcie_bram_s6_core across four width/register configs.
module tb_pcie_bram_s6_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wen;
   logic [3:0]  ren;
   logic [3:0]  rce;
   logic [11:0] waddr;
   logic [11:0] raddr;
   logic [35:0] wdata;
   logic [35:0] r36;
   logic [17:0] r18;
   logic [8:0]  r9;
   logic [3:0]  r4;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pcie_bram_s6_core #(.DOB_REG(0), .WIDTH(36)) u36 (
      .user_clk_i(clk), .reset_i(reset),
      .wen_i(wen[0]), .waddr_i(waddr), .wdata_i(wdata),
      .ren_i(ren[0]), .rce_i(rce[0]), .raddr_i(raddr),
      .rdata_o(r36)
   );

   pcie_bram_s6_core #(.DOB_REG(1), .WIDTH(18)) u18 (
      .user_clk_i(clk), .reset_i(reset),
      .wen_i(wen[1]), .waddr_i(waddr), .wdata_i(wdata[17:0]),
      .ren_i(ren[1]), .rce_i(rce[1]), .raddr_i(raddr),
      .rdata_o(r18)
   );

   pcie_bram_s6_core #(.DOB_REG(0), .WIDTH(9)) u9 (
      .user_clk_i(clk), .reset_i(reset),
      .wen_i(wen[2]), .waddr_i(waddr), .wdata_i(wdata[8:0]),
      .ren_i(ren[2]), .rce_i(rce[2]), .raddr_i(raddr),
      .rdata_o(r9)
   );

   pcie_bram_s6_core #(.DOB_REG(1), .WIDTH(4)) u4 (
      .user_clk_i(clk), .reset_i(reset),
      .wen_i(wen[3]), .waddr_i(waddr), .wdata_i(wdata[3:0]),
      .ren_i(ren[3]), .rce_i(rce[3]), .raddr_i(raddr),
      .rdata_o(r4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs,
                      input logic [35:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1;
      wen   = '0;
      ren   = '0;
      rce   = '0;
      waddr = '0;
      raddr = '0;
      wdata = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_r36", 36'(r36), 36'h0);
      chk("rst_r18", 36'(r18), 36'h0);
      chk("rst_r9",  36'(r9),  36'h0);
      chk("rst_r4",  36'(r4),  36'h0);

      // basic write/read, latency 1
      wen[0] = 1'b1; waddr = 12'd5; wdata = 36'h123456789;
      tick();
      wen[0] = 1'b0;
      chk("w36_pre", 36'(r36), 36'h0);
      ren[0] = 1'b1; raddr = 12'd5;
      tick();
      ren[0] = 1'b0;
      chk("w36_rd", 36'(r36), 36'h123456789);

      // output register, latency 2
      wen[1] = 1'b1; waddr = 12'h3FF; wdata = 36'h2ABCD;
      tick();
      wen[1] = 1'b0;
      ren[1] = 1'b1; rce[1] = 1'b1; raddr = 12'h3FF;
      tick();
      ren[1] = 1'b0;
      chk("w18_lat1", 36'(r18), 36'h0);
      tick();
      chk("w18_lat2", 36'(r18), 36'h2ABCD);

      // read-first collision
      wen[2] = 1'b1; waddr = 12'd7; wdata = 36'h055;
      tick();
      wdata = 36'h1AA; ren[2] = 1'b1; raddr = 12'd7;
      tick();
      wen[2] = 1'b0;
      chk("w9_old", 36'(r9), 36'h055);
      tick();
      ren[2] = 1'b0;
      chk("w9_new", 36'(r9), 36'h1AA);

      // enable hold on both stages
      wen[3] = 1'b1; waddr = 12'd1; wdata = 36'hA;
      tick();
      waddr = 12'd2; wdata = 36'h3;
      tick();
      wen[3] = 1'b0;
      ren[3] = 1'b1; rce[3] = 1'b1; raddr = 12'd1;
      tick();
      tick();
      chk("w4_a", 36'(r4), 36'hA);
      ren[3] = 1'b0; rce[3] = 1'b0; raddr = 12'd2;
      tick();
      chk("w4_hold1", 36'(r4), 36'hA);
      tick();
      chk("w4_hold2", 36'(r4), 36'hA);
      rce[3] = 1'b1;
      tick();
      chk("w4_rce_only", 36'(r4), 36'hA);
      ren[3] = 1'b1;
      tick();
      chk("w4_edge1", 36'(r4), 36'hA);
      tick();
      chk("w4_edge2", 36'(r4), 36'h3);

      // reset mid-operation, memory retained
      chk("r36_held", 36'(r36), 36'h123456789);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_r36", 36'(r36), 36'h0);
      chk("mid_rst_r18", 36'(r18), 36'h0);
      chk("mid_rst_r9",  36'(r9),  36'h0);
      chk("mid_rst_r4",  36'(r4),  36'h0);
      ren[3] = 1'b0; rce[3] = 1'b0;
      ren[0] = 1'b1; raddr = 12'd5;
      tick();
      ren[0] = 1'b0;
      chk("post_rst_rd", 36'(r36), 36'h123456789);

      // address aliasing modulo depth
      wen[0] = 1'b1; waddr = 12'h200; wdata = 36'h0000000FF;
      tick();
      wen[0] = 1'b0;
      ren[0] = 1'b1; raddr = 12'h000;
      tick();
      chk("alias_rd", 36'(r36), 36'h0000000FF);
      raddr = 12'd5;
      tick();
      ren[0] = 1'b0;
      chk("alias_other", 36'(r36), 36'h123456789);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
